return_addr_stack: RTL

Hardware return-address stack (LIFO) serving the CPU branch controller. The controller pushes the return address on CALL and pops it on RET. The block stores up to DEPTH addresses, presents the current top of stack combinationally so RET can consume it in the same cycle as the pop, and reports occupancy plus sticky overflow/underflow errors for debug.

---
 rtl/return_addr_stack.sv | 93 +++++++++
 1 files changed

// File: rtl/return_addr_stack.sv
// Return-address stack: LIFO of call return addresses with a combinational top read.
// Reports occupancy plus sticky overflow/underflow flags for debug.
module return_addr_stack #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 32,
  parameter int PTRW  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic [PTRW:0]    count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTRW:0]    count_q;
  logic [PTRW:0]    count_d;
  logic [PTRW-1:0]  top_idx;
  logic [PTRW-1:0]  wr_idx;
  logic [PTRW-1:0]  widx;
  logic             we;
  logic             ovf_evt;
  logic             unf_evt;
  logic             ovf_q;
  logic             unf_q;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTRW+1)'(DEPTH));
  assign top_idx = PTRW'(count_q - 1'b1);
  assign wr_idx  = count_q[PTRW-1:0];

  // Stale entries stay in mem; the empty mask hides them.
  assign data_out  = empty ? '0 : mem[top_idx];
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  always_comb begin
    count_d = count_q;
    we      = 1'b0;
    widx    = wr_idx;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    unique case (1'b1)
      push & ~pop: begin
        if (full) begin
          ovf_evt = 1'b1;
        end else begin
          we      = 1'b1;
          count_d = count_q + 1'b1;
        end
      end
      ~push & pop: begin
        if (empty) unf_evt = 1'b1;
        else       count_d = count_q - 1'b1;
      end
      push & pop: begin
        we = 1'b1;
        if (empty) begin
          count_d = (PTRW+1)'(1);
          unf_evt = 1'b1;
        end else begin
          widx = top_idx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_evt | (ovf_q & ~clr_err);
      unf_q   <= unf_evt | (unf_q & ~clr_err);
    end
  end

endmodule
